braille_chord_decoder: RTL and testbench

Input-side counterpart to the braille converter, which turns characters into braille cells. This block reads six-dot braille chords from a Perkins-style keypad: six dot keys plus one space key, pressed together and then released. Key inputs are synchronised and debounced, and the keys pressed during one chord are ORed together. On full release the chord is decoded as Grade-1 braille to 8-bit ASCII, and the result is presented on a valid/ready output port. Capital-sign and number-sign prefixes are handled internally.

---
 rtl/braille_chord_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_braille_chord_decoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/braille_chord_decoder.sv
`default_nettype none
// ============================================================================
// Module      : braille_chord_decoder
// Description : Reads six-dot braille chords from a Perkins-style keypad.
//               Keys are synchronised and debounced, and the keys pressed
//               during one chord are ORed together. On full release the
//               chord is decoded as Grade-1 braille to ASCII and presented
//               on a valid/ready port. Capital and number prefixes are
//               tracked internally.
//               Optional build macro: BRAILLE_CAPS_WORD_EN (two consecutive
//               capital signs lock uppercase until a space or punctuation).
// Revision    : 1.0 - initial release
// ============================================================================
module braille_chord_decoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] dots_in,
    input  logic       space_in,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       err_pulse,
    output logic       overflow,
    output logic       num_mode,
    output logic       cap_pending
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CHORD  = 2'd1;
    localparam logic [1:0] c_ST_DECODE = 2'd2;

    localparam logic [7:0] c_DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0] c_CAP_SIGN  = 6'h20;
    localparam logic [5:0] c_NUM_SIGN  = 6'h3C;
    localparam logic [7:0] c_CH_SPACE  = 8'h20;
    localparam logic [7:0] c_CH_ERROR  = 8'h3F;

    // ------------------------------------------------------------------
    // Input synchroniser and debounce
    // ------------------------------------------------------------------
    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [6:0] r_last;
    logic [6:0] r_stable;
    logic [7:0] r_cnt;

    // Two-flop synchroniser for the asynchronous key inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {space_in, dots_in};
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new key vector only after it has been seen unchanged for
    // DEBOUNCE_CYCLES consecutive cycles; any wobble restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_last <= r_sync2;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_sync2 != r_last) begin
                r_cnt <= 8'd1;
            end else if (r_cnt >= c_DB_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Chord FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_acc_clr;
    logic       w_acc_en;
    logic       w_decode_en;
    logic [6:0] r_acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a chord starts on any key and ends on full release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (r_stable != 7'd0) w_state_nxt = c_ST_CHORD;
            c_ST_CHORD:  if (r_stable == 7'd0) w_state_nxt = c_ST_DECODE;
            c_ST_DECODE: w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM outputs controlling the accumulator and the decode strobe
    always_comb begin
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_decode_en = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_acc_clr   = (r_stable != 7'd0);
            c_ST_CHORD:  w_acc_en    = 1'b1;
            c_ST_DECODE: w_decode_en = 1'b1;
            default:     w_acc_clr   = 1'b0;
        endcase
    end

    // Accumulate every key seen during the chord
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_acc_clr) begin
            r_acc <= '0;
        end else if (w_acc_en) begin
            r_acc <= r_acc | r_stable;
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0] w_pat;
    logic       w_space;
    logic       w_is_letter;
    logic [4:0] w_idx;
    logic       w_is_punct;
    logic [7:0] w_punct_char;
    logic       w_upper;

    logic       r_num;
    logic       r_cap;
    logic [7:0] r_char;
    logic       r_valid;
    logic       r_err;
    logic       r_overflow;

    logic       w_emit;
    logic [7:0] w_char;
    logic       w_err;
    logic       w_num_nxt;
    logic       w_cap_nxt;

`ifdef BRAILLE_CAPS_WORD_EN
    logic       r_caps_word;
    logic       r_last_cap;
    logic       w_cw_nxt;
    logic       w_last_cap_nxt;
    assign w_upper = r_cap | r_caps_word;
`else
    assign w_upper = r_cap;
`endif

    assign w_pat   = r_acc[5:0];
    assign w_space = r_acc[6];

    // Letter pattern to alphabet index (a=0 .. z=25)
    always_comb begin
        w_is_letter = 1'b1;
        w_idx       = 5'd0;
        case (w_pat)
            6'h01: w_idx = 5'd0;
            6'h03: w_idx = 5'd1;
            6'h09: w_idx = 5'd2;
            6'h19: w_idx = 5'd3;
            6'h11: w_idx = 5'd4;
            6'h0B: w_idx = 5'd5;
            6'h1B: w_idx = 5'd6;
            6'h13: w_idx = 5'd7;
            6'h0A: w_idx = 5'd8;
            6'h1A: w_idx = 5'd9;
            6'h05: w_idx = 5'd10;
            6'h07: w_idx = 5'd11;
            6'h0D: w_idx = 5'd12;
            6'h1D: w_idx = 5'd13;
            6'h15: w_idx = 5'd14;
            6'h0F: w_idx = 5'd15;
            6'h1F: w_idx = 5'd16;
            6'h17: w_idx = 5'd17;
            6'h0E: w_idx = 5'd18;
            6'h1E: w_idx = 5'd19;
            6'h25: w_idx = 5'd20;
            6'h27: w_idx = 5'd21;
            6'h3A: w_idx = 5'd22;
            6'h2D: w_idx = 5'd23;
            6'h3D: w_idx = 5'd24;
            6'h35: w_idx = 5'd25;
            default: w_is_letter = 1'b0;
        endcase
    end

    // Punctuation pattern to ASCII
    always_comb begin
        w_is_punct   = 1'b1;
        w_punct_char = c_CH_ERROR;
        case (w_pat)
            6'h02: w_punct_char = 8'h2C;
            6'h32: w_punct_char = 8'h2E;
            6'h16: w_punct_char = 8'h21;
            6'h24: w_punct_char = 8'h2D;
            6'h26: w_punct_char = 8'h3F;
            default: w_is_punct = 1'b0;
        endcase
    end

    // Chord interpretation and next prefix-mode state
    always_comb begin
        w_emit    = 1'b0;
        w_char    = c_CH_ERROR;
        w_err     = 1'b0;
        w_num_nxt = r_num;
        w_cap_nxt = r_cap;
`ifdef BRAILLE_CAPS_WORD_EN
        w_cw_nxt       = r_caps_word;
        w_last_cap_nxt = 1'b0;
`endif
        if (w_space) begin
            w_emit = 1'b1;
            if (w_pat == 6'd0) begin
                w_char    = c_CH_SPACE;
                w_num_nxt = 1'b0;
                w_cap_nxt = 1'b0;
`ifdef BRAILLE_CAPS_WORD_EN
                w_cw_nxt  = 1'b0;
`endif
            end else begin
                w_err = 1'b1;
            end
        end else if (w_pat == c_CAP_SIGN) begin
            w_cap_nxt = 1'b1;
`ifdef BRAILLE_CAPS_WORD_EN
            w_last_cap_nxt = 1'b1;
            if (r_last_cap) w_cw_nxt = 1'b1;
`endif
        end else if (w_pat == c_NUM_SIGN) begin
            w_num_nxt = 1'b1;
            w_cap_nxt = 1'b0;
`ifdef BRAILLE_CAPS_WORD_EN
            w_cw_nxt  = 1'b0;
`endif
        end else if (w_is_letter) begin
            w_emit    = 1'b1;
            w_cap_nxt = 1'b0;
            if (r_num && (w_idx < 5'd10)) begin
                // a..j double as digits 1..9,0 in numeric mode
                w_char = (w_idx == 5'd9) ? 8'h30 : (8'h31 + {3'b000, w_idx});
            end else begin
                w_num_nxt = 1'b0;
                w_char    = w_upper ? (8'h41 + {3'b000, w_idx})
                                    : (8'h61 + {3'b000, w_idx});
            end
        end else if (w_is_punct) begin
            w_emit    = 1'b1;
            w_char    = w_punct_char;
            w_num_nxt = 1'b0;
`ifdef BRAILLE_CAPS_WORD_EN
            w_cw_nxt  = 1'b0;
`endif
        end else begin
            w_emit    = 1'b1;
            w_err     = 1'b1;
            w_num_nxt = 1'b0;
            w_cap_nxt = 1'b0;
`ifdef BRAILLE_CAPS_WORD_EN
            w_cw_nxt  = 1'b0;
`endif
        end
    end

    // Output port, mode flags and overflow; a character decoded while the
    // previous one is still unaccepted is dropped but its mode effects stay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num      <= 1'b0;
            r_cap      <= 1'b0;
            r_char     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_valid && char_ready) begin
                r_valid <= 1'b0;
            end
            if (w_decode_en) begin
                r_num <= w_num_nxt;
                r_cap <= w_cap_nxt;
                if (w_emit) begin
                    if (r_valid) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_valid <= 1'b1;
                        r_char  <= w_char;
                        r_err   <= w_err;
                    end
                end
            end
        end
    end

`ifdef BRAILLE_CAPS_WORD_EN
    // Caps-word lock and consecutive-capital-sign tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_caps_word <= 1'b0;
            r_last_cap  <= 1'b0;
        end else if (w_decode_en) begin
            r_caps_word <= w_cw_nxt;
            r_last_cap  <= w_last_cap_nxt;
        end
    end

    assign cap_pending = r_cap | r_caps_word;
`else
    assign cap_pending = r_cap;
`endif

    assign char_out   = r_char;
    assign char_valid = r_valid;
    assign err_pulse  = r_err;
    assign overflow   = r_overflow;
    assign num_mode   = r_num;

endmodule
`default_nettype wire

// File: tb/tb_braille_chord_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_braille_chord_decoder
// Description : Self-checking bench for braille_chord_decoder: directed
//               scenarios followed by random chords checked against a
//               table-driven Grade-1 reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_braille_chord_decoder;

    localparam int DB = 16;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [5:0] dots_in    = '0;
    logic       space_in   = 1'b0;
    logic       char_ready = 1'b1;
    logic [7:0] char_out;
    logic       char_valid;
    logic       err_pulse;
    logic       overflow;
    logic       num_mode;
    logic       cap_pending;

    always #5 clk = ~clk;

    braille_chord_decoder #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dots_in     (dots_in),
        .space_in    (space_in),
        .char_out    (char_out),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .err_pulse   (err_pulse),
        .overflow    (overflow),
        .num_mode    (num_mode),
        .cap_pending (cap_pending)
    );

    int checks = 0;
    int errors = 0;

    // Transfer monitor
    logic [7:0] got_ch [$];
    bit         got_err[$];
    int         valid_cycles = 0;
    int         err_cycles   = 0;

    always @(negedge clk) begin
        if (char_valid) valid_cycles++;
        if (err_pulse)  err_cycles++;
        if (char_valid && char_ready) begin
            got_ch.push_back(char_out);
            got_err.push_back(err_pulse);
        end
    end

    // Reference model: Grade-1 tables plus prefix state
    logic [5:0] letter_pat [26] = '{6'h01, 6'h03, 6'h09, 6'h19, 6'h11, 6'h0B, 6'h1B,
                                   6'h13, 6'h0A, 6'h1A, 6'h05, 6'h07, 6'h0D, 6'h1D,
                                   6'h15, 6'h0F, 6'h1F, 6'h17, 6'h0E, 6'h1E, 6'h25,
                                   6'h27, 6'h3A, 6'h2D, 6'h3D, 6'h35};
    logic [5:0] punct_pat [5]  = '{6'h02, 6'h32, 6'h16, 6'h24, 6'h26};
    logic [7:0] punct_ch  [5]  = '{8'h2C, 8'h2E, 8'h21, 8'h2D, 8'h3F};
    logic [7:0] digit_ch  [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                   8'h36, 8'h37, 8'h38, 8'h39, 8'h30};
    bit m_num = 1'b0;
    bit m_cap = 1'b0;

    bit         exp_emit;
    logic [7:0] exp_ch;
    bit         exp_err;
    int         vc0, ec0;

    task automatic model(input logic [6:0] v, output bit emit, output logic [7:0] ch,
                         output bit err);
        int li = -1;
        int pi = -1;
        logic [5:0] p = v[5:0];
        emit = 1'b0; ch = 8'h00; err = 1'b0;
        for (int i = 0; i < 26; i++) if (letter_pat[i] == p) li = i;
        for (int i = 0; i < 5; i++)  if (punct_pat[i] == p)  pi = i;
        if (v[6]) begin
            emit = 1'b1;
            if (p == 6'd0) begin ch = 8'h20; m_num = 1'b0; m_cap = 1'b0; end
            else begin ch = 8'h3F; err = 1'b1; end
        end else if (p == 6'h20) begin
            m_cap = 1'b1;
        end else if (p == 6'h3C) begin
            m_num = 1'b1; m_cap = 1'b0;
        end else if (li >= 0) begin
            emit = 1'b1;
            if (m_num && li < 10) ch = digit_ch[li];
            else begin
                m_num = 1'b0;
                ch = m_cap ? 8'(65 + li) : 8'(97 + li);
            end
            m_cap = 1'b0;
        end else if (pi >= 0) begin
            emit = 1'b1; ch = punct_ch[pi]; m_num = 1'b0;
        end else begin
            emit = 1'b1; ch = 8'h3F; err = 1'b1; m_num = 1'b0; m_cap = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] first_ch();
        return (got_ch.size() > 0) ? got_ch[0] : 8'hxx;
    endfunction

    function automatic bit first_err();
        return (got_err.size() > 0) ? got_err[0] : 1'b1;
    endfunction

    task automatic drive(input logic [6:0] v, input int n);
        {space_in, dots_in} = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press keys in three phases (subset, full chord, subset), release,
    // and let the decode settle; expected results come from the model
    task automatic run_chord(input logic [6:0] pre, input logic [6:0] full,
                             input logic [6:0] post, input int hold);
        got_ch.delete();
        got_err.delete();
        vc0 = valid_cycles;
        ec0 = err_cycles;
        drive(pre, hold);
        drive(full, hold);
        drive(post, hold);
        drive(7'h00, DB + 14);
        model(full, exp_emit, exp_ch, exp_err);
    endtask

    task automatic check_chord();
        chk("xfer_count", got_ch.size(), exp_emit ? 1 : 0);
        chk("valid_cycles", valid_cycles - vc0, exp_emit ? 1 : 0);
        chk("err_pulses", err_cycles - ec0, exp_err ? 1 : 0);
        if (exp_emit) begin
            chk("char", first_ch(), exp_ch);
            chk("err_at_xfer", first_err(), exp_err);
        end
        chk("num_mode", num_mode, m_num);
        chk("cap_pending", cap_pending, m_cap);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_char_out"}, char_out, 8'h00);
        chk({tag, "_char_valid"}, char_valid, 1'b0);
        chk({tag, "_err_pulse"}, err_pulse, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_num_mode"}, num_mode, 1'b0);
        chk({tag, "_cap_pending"}, cap_pending, 1'b0);
    endtask

    initial begin
        logic [6:0] f, a, b;
        int cat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: dot1 held ~100 cycles -> 'a', single valid cycle
        run_chord(7'h01, 7'h01, 7'h01, 34);
        check_chord();
        chk("t1_char", first_ch(), 8'h61);
        chk("t1_valid_cycles", valid_cycles - vc0, 1);
        chk("t1_err", err_cycles - ec0, 0);

        // 2: capital sign then 'b' -> 'B'
        run_chord(7'h20, 7'h20, 7'h20, 25);
        check_chord();
        chk("t2_cap_between", cap_pending, 1'b1);
        chk("t2_no_output", got_ch.size(), 0);
        run_chord(7'h03, 7'h03, 7'h03, 25);
        check_chord();
        chk("t2_char", first_ch(), 8'h42);
        chk("t2_cap_after", cap_pending, 1'b0);

        // 3: number sign, 'a', 'j', space, 'a'
        run_chord(7'h3C, 7'h3C, 7'h3C, 25);
        check_chord();
        chk("t3_num_set", num_mode, 1'b1);
        run_chord(7'h01, 7'h01, 7'h01, 25);
        check_chord();
        chk("t3_digit1", first_ch(), 8'h31);
        run_chord(7'h1A, 7'h1A, 7'h1A, 25);
        check_chord();
        chk("t3_digit0", first_ch(), 8'h30);
        chk("t3_num_kept", num_mode, 1'b1);
        run_chord(7'h40, 7'h40, 7'h40, 25);
        check_chord();
        chk("t3_space", first_ch(), 8'h20);
        chk("t3_num_clear", num_mode, 1'b0);
        run_chord(7'h01, 7'h01, 7'h01, 25);
        check_chord();
        chk("t3_letter", first_ch(), 8'h61);

        // 4: pulse one cycle too short is ignored; exactly long enough is taken
        got_ch.delete();
        vc0 = valid_cycles;
        drive(7'h01, DB - 1);
        drive(7'h00, 40);
        chk("t4_short_xfer", got_ch.size(), 0);
        chk("t4_short_valid", valid_cycles - vc0, 0);
        got_ch.delete();
        drive(7'h01, DB);
        drive(7'h00, 40);
        model(7'h01, exp_emit, exp_ch, exp_err);
        chk("t4_exact_xfer", got_ch.size(), 1);
        chk("t4_exact_char", first_ch(), 8'h61);

        // 5: consumer stalled, second chord overflows
        char_ready = 1'b0;
        run_chord(7'h01, 7'h01, 7'h01, 25);
        chk("t5_valid", char_valid, 1'b1);
        chk("t5_char_first", char_out, 8'h61);
        chk("t5_no_overflow_yet", overflow, 1'b0);
        run_chord(7'h03, 7'h03, 7'h03, 25);
        chk("t5_overflow", overflow, 1'b1);
        chk("t5_char_held", char_out, 8'h61);
        chk("t5_valid_held", char_valid, 1'b1);
        got_ch.delete();
        char_ready = 1'b1;
        drive(7'h00, 10);
        chk("t5_one_xfer", got_ch.size(), 1);
        chk("t5_xfer_char", first_ch(), 8'h61);
        chk("t5_valid_drop", char_valid, 1'b0);
        chk("t5_overflow_sticky", overflow, 1'b1);

        // 6: undecodable chord, then reset in the middle of a chord
        run_chord(7'h3F, 7'h3F, 7'h3F, 25);
        check_chord();
        chk("t6_err_char", first_ch(), 8'h3F);
        chk("t6_err_pulse", err_cycles - ec0, 1);
        run_chord(7'h20, 7'h20, 7'h20, 25);
        chk("t6_cap_set", cap_pending, 1'b1);
        got_ch.delete();
        drive(7'h09, 30);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        m_num = 1'b0;
        m_cap = 1'b0;
        {space_in, dots_in} = 7'h00;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vc0 = valid_cycles;
        drive(7'h00, 40);
        chk("t6_no_char_after", got_ch.size(), 0);
        chk("t6_no_valid_after", valid_cycles - vc0, 0);

        // Random chords against the reference model
        for (int k = 0; k < 120; k++) begin
            cat = $urandom_range(0, 9);
            case (cat)
                0, 1, 2, 3, 4: f = {1'b0, letter_pat[$urandom_range(0, 25)]};
                5:             f = 7'h20;
                6:             f = 7'h3C;
                7:             f = 7'h40;
                8:             f = {1'b0, punct_pat[$urandom_range(0, 4)]};
                default:       f = 7'($urandom_range(1, 127));
            endcase
            a = f & 7'($urandom);
            b = f & 7'($urandom);
            run_chord(a, f, b, 25);
            check_chord();
        end
        chk("final_overflow", overflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
